data_mem_responder: RTL and testbench

//  Multi-cycle data-memory responder that serves MEM-stage load/store requests from the pipeline.
//  The MEM stage acts as the initiator; this block accepts a request, inserts WAIT_STATES cycles,

---
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads and stores.
// A request is captured in IDLE and followed by WAIT_STATES wait cycles.
// The access is then performed in RESP, where ack pulses for one cycle.
// Memory is a byte array with big-endian word packing.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              ack,
  output logic              err,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              cap_rw;
  logic              cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic              misaligned;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       word_rd;

  // Word lanes come from the captured address with its low bits forced.
  // A misaligned word is rejected, so forcing the low bits never aliases a legal access.
  assign misaligned = cap_size & (cap_addr[1:0] != 2'b00);
  assign a0 = {cap_addr[ADDR_W-1:2], 2'd0};
  assign a1 = {cap_addr[ADDR_W-1:2], 2'd1};
  assign a2 = {cap_addr[ADDR_W-1:2], 2'd2};
  assign a3 = {cap_addr[ADDR_W-1:2], 2'd3};
  assign word_rd = {mem[a0], mem[a1], mem[a2], mem[a3]};

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request capture in IDLE and wait-state countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      cap_rw   <= 1'b0;
      cap_size <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt      <= WAIT_INIT;
            cap_rw   <= rw;
            cap_size <= size;
            cap_addr <= addr;
            cap_data <= data_in;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Store commits on the edge that ends RESP; reset low on that edge aborts it
  always_ff @(posedge clk) begin
    if (reset && state == RESP && cap_rw && !misaligned) begin
      if (cap_size) begin
        mem[a0] <= cap_data[31:24];
        mem[a1] <= cap_data[23:16];
        mem[a2] <= cap_data[15:8];
        mem[a3] <= cap_data[7:0];
      end else begin
        mem[cap_addr] <= cap_data[7:0];
      end
    end
  end

  // Next-state logic and response outputs
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    err        = 1'b0;
    data_out   = '0;
    case (state)
      IDLE: begin
        if (req) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        ack        = 1'b1;
        err        = misaligned;
        if (!cap_rw && !misaligned) begin
          data_out = cap_size ? word_rd : {24'b0, mem[cap_addr]};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold the pipeline while a request is pending and not yet acknowledged
  assign stall = req & ~ack;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// Uses one instance with WAIT_STATES=2 and one with WAIT_STATES=0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw, size;
  logic [7:0]  addr;
  logic [31:0] data_in, data_out;
  logic        ack, err, stall;

  logic        z_req, z_rw, z_size;
  logic [7:0]  z_addr;
  logic [31:0] z_data_in, z_data_out;
  logic        z_ack, z_err, z_stall;

  int unsigned num_checks = 0;
  int unsigned num_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .err(err), .stall(stall)
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(z_req), .rw(z_rw), .size(z_size), .addr(z_addr),
    .data_in(z_data_in), .data_out(z_data_out), .ack(z_ack), .err(z_err), .stall(z_stall)
  );

  typedef struct {
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input logic r, input logic s, input logic [7:0] a, input logic [31:0] d,
                        input int unsigned lat, output logic [31:0] rd, output logic e);
    int unsigned k;
    logic seen, side_ok;
    @(posedge clk); #1;
    req = 1'b1; rw = r; size = s; addr = a; data_in = d;
    seen = 1'b0; side_ok = 1'b1; rd = '0; e = 1'b0; k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1; k = i; rd = data_out; e = err;
        if (stall !== 1'b0) side_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1 || err !== 1'b0 || data_out !== 32'h0) side_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("ack_seen", {31'b0, seen}, 32'd1);
    check("latency", k, lat);
    check("stall_and_idle_outputs", {31'b0, side_ok}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  task automatic z_access(input logic r, input logic s, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    z_req = 1'b1; z_rw = r; z_size = s; z_addr = a; z_data_in = d;
    @(negedge clk);
    check("z_cycle0_ack", {31'b0, z_ack}, 32'd0);
    check("z_cycle0_stall", {31'b0, z_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("z_cycle1_ack", {31'b0, z_ack}, 32'd1);
    check("z_cycle1_stall", {31'b0, z_stall}, 32'd0);
    rd = z_data_out; e = z_err;
    @(posedge clk); #1;
    z_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int unsigned c_ack;
    logic [7:0]  b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    //            rw    size  addr   wdata          exp_data       exp_err
    vecs[0]  = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h10, 32'h0,        32'h000000DE, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h11, 32'h0,        32'h000000AD, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h12, 32'h0,        32'h000000BE, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h13, 32'h0,        32'h000000EF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h12, 32'hFFFFFF5A, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'hDEAD5AEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h21, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h22, 32'h11111111, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h20, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hFC, 32'hA1B2C3D4, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'hFC, 32'h0,        32'hA1B2C3D4, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'h000000D4, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'h40, 32'hAABBCCDD, 32'h00000000, 1'b0};

    b2b_addr[0] = 8'h10; b2b_exp[0] = 32'hDEAD5AEF;
    b2b_addr[1] = 8'h20; b2b_exp[1] = 32'hCAFEF00D;
    b2b_addr[2] = 8'hFC; b2b_exp[2] = 32'hA1B2C3D4;

    reset = 1'b0; req = 1'b1; rw = 1'b0; size = 1'b1; addr = 8'h10; data_in = '0;
    z_req = 1'b0; z_rw = 1'b0; z_size = 1'b0; z_addr = '0; z_data_in = '0;

    // Reset held with req high: no ack, stall follows req
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("rst%0d_ack", i), {31'b0, ack}, 32'd0);
      check($sformatf("rst%0d_stall", i), {31'b0, stall}, 32'd1);
      check($sformatf("rst%0d_data", i), data_out, 32'd0);
    end
    reset = 1'b1;
    c_ack = 99;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      if (ack) begin
        c_ack = c;
        break;
      end
    end
    check("post_reset_ack_cycle", c_ack, 32'd3);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);

    // Table-driven accesses
    for (int i = 0; i < 16; i++) begin
      access(vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, 3, rd, e);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end

    // Back-to-back reads with req held; inputs scrambled during waits
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req = 1'b1; rw = 1'b0;
      if (c % 4 == 0) begin
        addr = b2b_addr[c / 4]; size = 1'b1;
      end else begin
        addr = 8'h40; size = 1'b0; data_in = 32'h55555555;
      end
      @(negedge clk);
      check($sformatf("b2b_c%0d_ack", c), {31'b0, ack}, {31'b0, (c % 4 == 3)});
      check($sformatf("b2b_c%0d_stall", c), {31'b0, stall}, {31'b0, (c % 4 != 3)});
      if (c % 4 == 3) check($sformatf("b2b_c%0d_data", c), data_out, b2b_exp[c / 4]);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);

    // Reset during the wait of a store aborts it
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b1; size = 1'b1; addr = 8'h40; data_in = 32'h12345678;
    @(negedge clk);
    check("abort_c0_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_c1_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("abort_rst%0d_ack", i), {31'b0, ack}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    access(1'b0, 1'b1, 8'h40, 32'h0, 3, rd, e);
    check("abort_read_old", rd, 32'hAABBCCDD);

    // Zero wait states: ack one cycle after request
    z_access(1'b1, 1'b1, 8'h08, 32'h0F0E0D0C, rd, e);
    check("z_write_data", rd, 32'h0);
    z_access(1'b0, 1'b1, 8'h08, 32'h0, rd, e);
    check("z_read_word", rd, 32'h0F0E0D0C);
    check("z_read_err", {31'b0, e}, 32'd0);
    z_access(1'b0, 1'b0, 8'h0B, 32'h0, rd, e);
    check("z_read_byte", rd, 32'h0000000C);
    z_access(1'b0, 1'b1, 8'h0A, 32'h0, rd, e);
    check("z_misaligned_err", {31'b0, e}, 32'd1);
    check("z_misaligned_data", rd, 32'h0);

    // Zero wait states: reset on the edge ending RESP aborts the store
    @(posedge clk); #1;
    z_req = 1'b1; z_rw = 1'b1; z_size = 1'b1; z_addr = 8'h08; z_data_in = 32'h99999999;
    @(posedge clk); #1;
    reset = 1'b0; z_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    z_access(1'b0, 1'b1, 8'h08, 32'h0, rd, e);
    check("z_abort_read_old", rd, 32'h0F0E0D0C);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
